// File: rtl/passage_pkg.sv
// passage_pkg: state encoding, default parameters and helpers for the passage scheduler
package passage_pkg;
  typedef enum logic [2:0] {S_IDLE, S_OPENING, S_OPEN, S_STEP, S_CLOSING} state_e;
  localparam int OPEN_LAT_DEF = 2;
  localparam int CLOSE_LAT_DEF = 2;
  localparam int TMO_DEF = 16;
  localparam int NZONE_DEF = 10;
  localparam logic [1:0] GNT_NONE = 2'b00;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-agent round-robin arbiter holding its grant until advanced
module rr_arb2
  import passage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic [1:0] gnt_q, gnt_d;
  logic       pri_q, pri_d;
  // grant only when free; advance releases the grant and favours the other agent next
  always_comb begin
    pri_d = advance ? gnt_q[0] : pri_q;
    gnt_d = advance ? GNT_NONE : (gnt_q != GNT_NONE) ? gnt_q : (req == 2'b11) ? (pri_q ? 2'b10 : 2'b01) : req;
  end
  // grant and priority registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q <= GNT_NONE;
      pri_q <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      pri_q <= pri_d;
    end
  end
  assign gnt = gnt_q;
endmodule

// File: rtl/passage_scheduler.sv
// passage_scheduler: grants a door passage to one of two agents and tracks its walk through the zones
module passage_scheduler
  import passage_pkg::*;
#(
  parameter int OPEN_LAT = OPEN_LAT_DEF,
  parameter int CLOSE_LAT = CLOSE_LAT_DEF,
  parameter int TMO = TMO_DEF,
  parameter int NZONE = NZONE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic             iup,
  input  logic             iright,
  output logic [1:0]       gnt,
  output logic             open,
  output logic             doorstep,
  output logic [NZONE-1:0] zone,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err
);
  localparam int CW = $clog2(max3(OPEN_LAT, CLOSE_LAT, TMO) + 1);
  localparam logic [NZONE-1:0] Z0 = NZONE'(1);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NZONE-1:0] zone_q, zone_d;
  logic             done_q, done_d, tmo_q, tmo_d, err_q, err_d;
  logic             advance, held, up, last;
  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      zone_q  <= Z0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zone_q  <= zone_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end
  // next state: withdrawal beats illegal moves, which beat timeout and progress
  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    err_d   = err_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    advance = 1'b0;
    up      = 1'b0;
    held    = |(req & gnt);
    last    = cnt_q == CW'(TMO - 1);
    case (state_q)
      S_IDLE: state_d = |req ? S_OPENING : S_IDLE;
      S_OPENING: state_d = !held ? S_CLOSING : (cnt_q == CW'(OPEN_LAT - 1)) ? S_OPEN : S_OPENING;
      S_OPEN: begin
        if (!held) state_d = S_CLOSING;
        else if (iup) begin
          err_d   = 1'b1;
          state_d = S_CLOSING;
        end else if (last) begin
          tmo_d   = 1'b1;
          state_d = S_CLOSING;
        end else if (iright) state_d = S_STEP;
      end
      S_STEP: begin
        if (!held) state_d = S_CLOSING;
        else if (iup) begin
          err_d   = 1'b1;
          state_d = S_CLOSING;
        end else if (iright) begin
          up     = 1'b1;
          zone_d = zone_q << 1;
          if (zone_q[NZONE-2]) begin
            done_d  = 1'b1;
            state_d = S_CLOSING;
          end
        end else begin
          zone_d = zone_q[0] ? zone_q : zone_q >> 1;
          if (last) begin
            tmo_d   = 1'b1;
            state_d = S_CLOSING;
          end
        end
      end
      S_CLOSING: begin
        zone_d = Z0;
        if (cnt_q == CW'(CLOSE_LAT - 1)) begin
          advance = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_q == S_IDLE || up || (state_d != state_q && !(state_q == S_OPEN && state_d == S_STEP))) ? '0
          : (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  end
  // outputs decoded from the current state and registered pulses
  always_comb begin
    open     = state_q == S_OPEN || state_q == S_STEP;
    doorstep = state_q == S_STEP;
    busy     = state_q != S_IDLE;
    zone     = zone_q;
    done     = done_q;
    timeout  = tmo_q;
    err      = err_q;
  end
endmodule

// File: tb/tb_passage_scheduler.sv
// tb_passage_scheduler: directed scoreboard bench for passage_scheduler
module tb_passage_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       iup = 1'b0;
  logic       iright = 1'b0;
  logic [1:0] gnt;
  logic       open, doorstep, busy, done, timeout, err;
  logic [9:0] zone;
  int         passed = 0;
  int         total = 0;
  logic [1:0] gq[$];
  logic [9:0] zq[$];

  always #5 clk = ~clk;

  passage_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .iup      (iup),
    .iright   (iright),
    .gnt      (gnt),
    .open     (open),
    .doorstep (doorstep),
    .zone     (zone),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_open"}, 32'(open), 0);
    chk({tag, "_doorstep"}, 32'(doorstep), 0);
    chk({tag, "_zone"}, 32'(zone), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk(tag, 32'(busy), 0);
  endtask

  initial begin
    int n, dn, grants, idle;
    logic [9:0] zprev;
    logic [1:0] gprev;
    tick();
    tick();
    chk_reset("rst");
    rst_n = 1'b1;
    req = 2'b01;
    iright = 1'b1;
    for (int b = 1; b < 10; b++) zq.push_back(10'(1 << b));
    tick();
    chk("s_gnt", 32'(gnt), 1);
    chk("s_open_entry", 32'(open), 0);
    tick();
    chk("s_open_mid", 32'(open), 0);
    tick();
    chk("s_open_rise", 32'(open), 1);
    zprev = zone;
    dn = 0;
    for (int i = 0; i < 30 && dn == 0; i++) begin
      tick();
      if (zone !== zprev && zq.size() > 0) chk("s_zone", 32'(zone), 32'(zq.pop_front()));
      zprev = zone;
      if (done) dn++;
    end
    chk("s_done_seen", 32'(dn), 1);
    chk("s_zq_empty", 32'(zq.size()), 0);
    req = 2'b00;
    tick();
    chk("s_done_pulse", 32'(done), 0);
    chk("s_gnt_held", 32'(gnt), 1);
    tick();
    chk("s_gnt_clear", 32'(gnt), 0);
    chk("s_idle", 32'(busy), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b11;
    gq.push_back(2'b01);
    gq.push_back(2'b10);
    gq.push_back(2'b01);
    grants = 0;
    idle = 0;
    gprev = gnt;
    for (int i = 0; i < 200 && grants < 3; i++) begin
      tick();
      if (gnt != 2'b00 && gprev == 2'b00) begin
        chk("c_gnt", 32'(gnt), 32'(gq.pop_front()));
        if (grants > 0) chk("c_idle_gap", 32'(idle >= 1), 1);
        grants++;
        idle = 0;
      end
      if (!busy) idle++;
      gprev = gnt;
    end
    chk("c_grants", 32'(grants), 3);
    req = 2'b00;
    wait_idle("c_idle");
    req = 2'b01;
    iright = 1'b0;
    for (int i = 0; i < 20 && !open; i++) tick();
    chk("t_open", 32'(open), 1);
    n = 0;
    dn = 0;
    for (int i = 0; i < 40 && !timeout; i++) begin
      tick();
      n++;
      if (done) dn++;
    end
    chk("t_cycles", 32'(n), 16);
    chk("t_done", 32'(dn), 0);
    chk("t_closing", 32'({open, busy}), 1);
    req = 2'b00;
    wait_idle("t_idle");
    req = 2'b01;
    iright = 1'b1;
    for (int i = 0; i < 30 && zone !== 10'h008; i++) tick();
    chk("i_zone3", 32'(zone), 8);
    iup = 1'b1;
    tick();
    chk("i_err", 32'(err), 1);
    chk("i_closing", 32'({open, busy}), 1);
    chk("i_zone_held", 32'(zone), 8);
    chk("i_done", 32'(done), 0);
    iup = 1'b0;
    req = 2'b00;
    wait_idle("i_idle");
    req = 2'b10;
    for (int i = 0; i < 10 && gnt == 2'b00; i++) tick();
    chk("i_gnt2", 32'(gnt), 2);
    chk("i_err_sticky", 32'(err), 1);
    for (int i = 0; i < 30 && zone !== 10'h020; i++) tick();
    chk("r_zone5", 32'(zone), 32'h20);
    chk("r_doorstep", 32'(doorstep), 1);
    rst_n = 1'b0;
    tick();
    chk_reset("r_mid");
    rst_n = 1'b1;
    req = 2'b11;
    tick();
    chk("r_rr_prio", 32'(gnt), 1);
    req = 2'b00;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/passage_scheduler.md
PASSAGE_SCHEDULER -- requirements
Module: passage_scheduler

Interface
REQ-001 The block SHALL have parameter OPEN_LAT, default 2, door-opening cycles.
REQ-002 The block SHALL have parameter CLOSE_LAT, default 2, door-closing cycles.
REQ-003 The block SHALL have parameter TMO, default 16, no-progress timeout in cycles.
REQ-004 The block SHALL have parameter NZONE, default 10, number of passageway zones.
REQ-005 Ports SHALL be: clk  in  1  single clock, all logic on posedge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req  in  2  per-agent traversal request, level, held until gnt or withdrawn.
REQ-008 iup  in  1  move of the granted agent, 1=up, 0=down.
REQ-009 iright  in  1  move of the granted agent, 1=right, 0=left.
REQ-010 gnt  out  2  one-hot grant, at most one bit set.
REQ-011 open  out  1  door open.
REQ-012 doorstep  out  1  granted agent on doorstep.
REQ-013 zone  out  NZONE  one-hot current zone.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse on arrival at zone NZONE-1.
REQ-016 timeout  out  1  one-cycle pulse on timeout abort.
REQ-017 err  out  1  sticky illegal-move flag.

Function
REQ-018 The FSM SHALL have states IDLE, OPENING, OPEN, STEP, CLOSING.
REQ-019 IDLE: open=0, doorstep=0, zone=one-hot bit 0, gnt=0; any req set -> assert gnt next cycle, go to OPENING.
REQ-020 Arbitration SHALL be round-robin: if both req bits are set, grant the agent not granted last; after reset, agent 0 has priority.
REQ-021 OPENING SHALL hold open=0 for exactly OPEN_LAT cycles, then go to OPEN with open=1.
REQ-022 OPEN: open=1; move iright=1,iup=0 -> STEP; move iup=1 -> err set, go to CLOSING.
REQ-023 STEP: open=1, doorstep=1; iright=1 -> zone shifts up one position; iright=0 -> zone shifts down one position, saturating at bit 0.
REQ-024 STEP: iup=1 SHALL set err and go to CLOSING; zone is held.
REQ-025 Entry of zone into bit NZONE-1 SHALL pulse done in the same cycle zone updates, then go to CLOSING.
REQ-026 In OPEN and STEP, a no-progress counter SHALL count cycles without a zone increase; on reaching TMO it SHALL pulse timeout and go to CLOSING.
REQ-027 Withdrawal of the granted req in OPENING, OPEN or STEP SHALL go to CLOSING next cycle, with no done or timeout pulse.
REQ-028 CLOSING: open=0, doorstep=0, zone=bit 0, gnt held; after exactly CLOSE_LAT cycles, clear gnt, update the round-robin pointer, go to IDLE.
REQ-029 A new grant SHALL NOT issue before IDLE has been occupied for at least one cycle.
REQ-030 err SHALL be sticky until reset; it SHALL NOT block further grants.
REQ-031 Counters SHALL be sized $clog2 of max(OPEN_LAT, CLOSE_LAT, TMO)+1 bits and SHALL NOT wrap.

Reset
REQ-032 While rst_n=0 at posedge: state=IDLE, gnt=0, open=0, doorstep=0, zone=one-hot bit 0, busy=0, done=0, timeout=0, err=0, all counters 0, RR pointer favours agent 0.
REQ-033 Reset asserted mid-traversal SHALL take effect on that edge, with no done or timeout pulse.

Structure
REQ-034 State encoding and default parameter constants SHALL reside in package passage_pkg.
REQ-035 The round-robin arbiter SHALL be a sub-module rr_arb2, with ports clk, rst_n, req, advance, gnt.

Verification
REQ-036 Single agent: req=01 with iright=1, iup=0 throughout -> gnt=01; open rises 2 cycles after OPENING entry; zone steps bits 0->9 one per cycle; done pulses once; gnt clears 2 cycles later.
REQ-037 Contention: req=11 held -> grants occur in order 01, 10, 01, with IDLE of at least 1 cycle between them.
REQ-038 Stall: in OPEN, iright=0 held -> timeout pulses after 16 cycles, then CLOSING; done=0 throughout.
REQ-039 Illegal move: in STEP with zone=bit 3, iup=1 -> err=1 and CLOSING; err remains 1 through the next grant.
REQ-040 Reset mid-STEP: rst_n=0 at zone=bit 5 -> next cycle all outputs at reset values, with no pulses.
